// File: rtl/instr_sequencer.sv
// Program-buffer instruction sequencer: buffers instruction words and replays
// them to the processor, holding each legal word for a fixed number of cycles.
module instr_sequencer #(
   parameter int DEPTH  = 16,
   parameter int HOLD_W = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_wr_en,
   input  logic [15:0]                i_wr_data,
   output logic                       o_wr_ready,
   input  logic                       i_clear,
   input  logic                       i_start,
   input  logic                       i_abort,
   input  logic [HOLD_W-1:0]          i_hold_cycles,
   output logic [15:0]                o_instruction,
   output logic                       o_instr_valid,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_err
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [15:0]         r_mem [DEPTH];
   logic [CW-1:0]       r_count;
   logic [IW-1:0]       r_idx;
   logic [HOLD_W-1:0]   r_hold;
   logic [HOLD_W-1:0]   r_hcnt;
   logic [15:0]         r_instr;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic                w_acc;
   logic [CW-1:0]       w_cnt_eff;
   logic [CW-1:0]       w_idx_inc;
   logic                w_last;
   logic [IW-1:0]       w_fetch_idx;
   logic [15:0]         w_fetch;
   logic                w_legal;
   logic                w_load;
   logic [HOLD_W-1:0]   w_h_eff;
   logic [IW-1:0]       w_idx_n;
   logic [HOLD_W-1:0]   w_hold_n;
   logic [HOLD_W-1:0]   w_hcnt_n;
   logic [15:0]         w_instr_n;
   logic                w_valid_n;
   logic                w_done_n;
   logic                w_err_n;

   assign o_wr_ready    = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
   assign o_instruction = r_instr;
   assign o_instr_valid = r_valid;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_count       = r_count;
   assign o_err         = r_err;

   // clear beats a same-cycle write; nothing is accepted while in reset
   assign w_acc     = i_reset & i_wr_en & o_wr_ready & ~i_clear;
   assign w_cnt_eff = (i_clear && r_state == S_IDLE) ? '0
                      : r_count + CW'(w_acc);
   assign w_idx_inc = {1'b0, r_idx} + CW'(1);
   assign w_last    = (w_idx_inc >= r_count);

   // entry 0 may be the word being written in the start cycle
   assign w_fetch_idx = (r_state == S_IDLE) ? '0 : w_idx_inc[IW-1:0];
   assign w_fetch     = (w_acc && r_count == {1'b0, w_fetch_idx})
                        ? i_wr_data : r_mem[w_fetch_idx];
   assign w_legal     = (w_fetch[13:11] == 3'b000);

   // program buffer write port
   always_ff @(posedge i_clk) begin
      if (w_acc) r_mem[r_count[IW-1:0]] <= i_wr_data;
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_start)
               w_state_nxt = (w_cnt_eff == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (i_abort)
               w_state_nxt = S_IDLE;
            else if (r_hcnt == '0 && w_last)
               w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // next values of the registered outputs and slot bookkeeping
   always_comb begin
      w_load    = 1'b0;
      w_h_eff   = r_hold;
      w_hold_n  = r_hold;
      w_idx_n   = r_idx;
      w_hcnt_n  = r_hcnt;
      w_instr_n = r_instr;
      w_valid_n = 1'b0;
      w_done_n  = 1'b0;
      w_err_n   = r_err;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_hold_n = (i_hold_cycles == '0) ? HOLD_W'(1) : i_hold_cycles;
               w_h_eff  = w_hold_n;
               w_err_n  = 1'b0;
               w_idx_n  = '0;
               if (w_cnt_eff == '0) w_done_n = 1'b1;
               else                 w_load   = 1'b1;
            end
         end
         S_RUN: begin
            if (!i_abort) begin
               if (r_hcnt != '0) begin
                  w_hcnt_n  = r_hcnt - HOLD_W'(1);
                  w_valid_n = r_valid;
               end else if (!w_last) begin
                  w_load  = 1'b1;
                  w_idx_n = w_idx_inc[IW-1:0];
               end else begin
                  w_done_n = 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (w_load) begin
         if (w_legal) begin
            w_instr_n = w_fetch;
            w_valid_n = 1'b1;
            w_hcnt_n  = w_h_eff - HOLD_W'(1);
         end else begin
            w_err_n  = 1'b1;
            w_hcnt_n = '0;
         end
      end
   end

   // datapath and output registers
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_count <= '0;
         r_idx   <= '0;
         r_hold  <= HOLD_W'(1);
         r_hcnt  <= '0;
         r_instr <= 16'h0000;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (i_clear && r_state == S_IDLE) r_count <= '0;
         else if (w_acc)                   r_count <= r_count + CW'(1);
         r_idx   <= w_idx_n;
         r_hold  <= w_hold_n;
         r_hcnt  <= w_hcnt_n;
         r_instr <= w_instr_n;
         r_valid <= w_valid_n;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= w_done_n;
         r_err   <= w_err_n;
      end
   end

endmodule
